// File: rtl/cq_pkg.sv
// cq_pkg: shared constants and types for the circular sample queue read sequencer.
package cq_pkg;

  localparam int unsigned CQ_DEPTH_LOG2 = 10;
  localparam int unsigned CQ_TAPS       = 1021;
  localparam int unsigned CQ_DECIM      = 2;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    IDLE = 2'd1,
    SEQ  = 2'd2
  } cq_state_t;

  typedef logic [CQ_DEPTH_LOG2-1:0] cq_addr_t;

endpackage

// File: rtl/cq_read_sequencer_decim.sv
// cq_decim: sample-strobe decimator; accept_c is high on the phase whose strobe is kept.
module cq_decim
  import cq_pkg::*;
#(
  parameter int unsigned DECIM = CQ_DECIM
) (
  input  logic clk,
  input  logic rst_n,
  input  logic wrt_smpl,
  output logic accept_c
);

  localparam int unsigned PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [PW-1:0] phase;

  assign accept_c = (phase == PW'(DECIM - 1));

  // Phase advances on every strobe and wraps after the accepted one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (wrt_smpl) begin
      phase <= accept_c ? '0 : phase + PW'(1);
    end
  end

endmodule

// File: rtl/cq_read_sequencer.sv
// cq_read_sequencer: write-pointer/fill tracking and oldest-first read burst generation
// for the circular sample queue. Optional macro CQ_OVERRUN_FLAG_EN enables the sticky
// overrun flag; without it overrun is tied low and extra requests are silently dropped.
module cq_read_sequencer
  import cq_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = CQ_DEPTH_LOG2,
  parameter int unsigned TAPS       = CQ_TAPS,
  parameter int unsigned DECIM      = CQ_DECIM
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wrt_smpl,
  output logic                  we,
  output logic [DEPTH_LOG2-1:0] waddr,
  output logic [DEPTH_LOG2-1:0] raddr,
  output logic                  sequencing,
  output logic                  rd_vld,
  output logic                  rd_first,
  output logic                  rd_last,
  output logic                  full,
  output logic                  overrun
);

  localparam int unsigned AW = DEPTH_LOG2;
  localparam int unsigned CW = $clog2(TAPS + 1);
  localparam int unsigned BW = (TAPS > 1) ? $clog2(TAPS) : 1;

  logic          accept_c;
  logic          wr_c;
  logic          fill_done_c;
  logic          last_c;
  logic          start_c;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_ptr_nxt_c;
  logic [AW-1:0] base_c;
  logic [AW-1:0] raddr_d;
  logic [CW-1:0] fill_cnt;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_d;
  logic          pending;
  logic          pending_d;
  logic          first;
  logic          first_d;
  cq_state_t     state;
  cq_state_t     state_d;

  cq_decim #(
    .DECIM (DECIM)
  ) u_decim (
    .clk      (clk),
    .rst_n    (rst_n),
    .wrt_smpl (wrt_smpl),
    .accept_c (accept_c)
  );

  assign wr_c         = wrt_smpl & accept_c;
  assign we           = wr_c;
  assign waddr        = wr_ptr;
  assign wr_ptr_nxt_c = wr_c ? wr_ptr + AW'(1) : wr_ptr;
  // Oldest sample of the window ending at the newest write, wrapping naturally.
  assign base_c       = wr_ptr_nxt_c - AW'(TAPS);
  assign fill_done_c  = wr_c && (fill_cnt == CW'(TAPS - 1));
  assign last_c       = (bcnt == BW'(TAPS - 1));

  // Write pointer, saturating fill count and full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      full     <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt_c;
      if (wr_c && (fill_cnt != CW'(TAPS))) begin
        fill_cnt <= fill_cnt + CW'(1);
      end
      if (fill_done_c) begin
        full <= 1'b1;
      end
    end
  end

  // Next-state logic; a request seen this cycle starts the burst on the next cycle.
  always_comb begin
    state_d   = state;
    raddr_d   = raddr;
    bcnt_d    = bcnt;
    pending_d = pending;
    first_d   = 1'b0;
    start_c   = 1'b0;
    case (state)
      FILL: begin
        if (fill_done_c) begin
          start_c = 1'b1;
        end
      end
      IDLE: begin
        if (wr_c) begin
          start_c = 1'b1;
        end
      end
      SEQ: begin
        if (last_c) begin
          if (pending || wr_c) begin
            start_c = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          raddr_d = raddr + AW'(1);
          bcnt_d  = bcnt + BW'(1);
          if (wr_c) begin
            pending_d = 1'b1;
          end
        end
      end
      default: state_d = FILL;
    endcase
    if (start_c) begin
      state_d   = SEQ;
      raddr_d   = base_c;
      bcnt_d    = '0;
      pending_d = 1'b0;
      first_d   = 1'b1;
    end
  end

  // State register and read-side outputs, flags delayed one cycle to match RAM latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FILL;
      raddr      <= '0;
      bcnt       <= '0;
      pending    <= 1'b0;
      first      <= 1'b0;
      sequencing <= 1'b0;
      rd_vld     <= 1'b0;
      rd_first   <= 1'b0;
      rd_last    <= 1'b0;
    end else begin
      state      <= state_d;
      raddr      <= raddr_d;
      bcnt       <= bcnt_d;
      pending    <= pending_d;
      first      <= first_d;
      sequencing <= (state_d == SEQ);
      rd_vld     <= sequencing;
      rd_first   <= sequencing & first;
      rd_last    <= sequencing & last_c;
    end
  end

`ifdef CQ_OVERRUN_FLAG_EN
  // Sticky: a second request arrived while one was already queued behind this burst.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if ((state == SEQ) && wr_c && pending) begin
      overrun <= 1'b1;
    end
  end
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: doc/cq_read_sequencer.md
# cq_read_sequencer

Controller for the low-frequency circular sample queue and its 1024x16 dual-port RAM. It decimates the incoming sample strobe and generates RAM write enables and write addresses. Once the queue holds a full filter window, it issues one burst of sequential read addresses per accepted sample, oldest sample first. Read-valid, first and last flags are aligned to RAM output data so the downstream FIR MAC can accumulate without its own address logic.

## Interface
- `DEPTH_LOG2`, default 10: RAM address width; queue depth is 2^DEPTH_LOG2.
- `TAPS`, default 1021: samples per read burst (filter length). Range 1 ≤ TAPS ≤ 2^DEPTH_LOG2 − 2.
- `DECIM`, default 2: accept one of every DECIM `wrt_smpl` pulses. DECIM ≥ 1.
- `clk` input, 1: sole clock, rising edge.
- `rst_n` input, 1: asynchronous, active-low reset.
- `wrt_smpl` input, 1: one-cycle strobe; new sample present on RAM `wdata` this cycle.
- `we` output, 1: RAM write enable, combinational `wrt_smpl & accept`.
- `waddr` output, DEPTH_LOG2: RAM write address, equal to the registered write pointer.
- `raddr` output, DEPTH_LOG2: RAM read address, registered.
- `sequencing` output, 1: high while the burst is issuing read addresses.
- `rd_vld` output, 1: RAM `rdata` valid this cycle, i.e. `sequencing` delayed by one cycle.
- `rd_first` output, 1: with `rd_vld`, marks the oldest sample of the burst.
- `rd_last` output, 1: with `rd_vld`, marks the newest sample; acts as the burst-done pulse.
- `full` output, 1: set once TAPS samples have been accepted since reset.
- `overrun` output, 1: sticky error flag (see Configuration).

## Operation
- **Decimation:** phase counter 0..DECIM−1.
  - Each `wrt_smpl` advances the phase.
  - The pulse seen at phase DECIM−1 is accepted. The 1st accepted pulse is the DECIM-th after reset.
- **Accepted write:**
  - `we`=1 at `waddr`=wr_ptr.
  - wr_ptr increments modulo 2^DEPTH_LOG2 (natural wrap).
  - fill count increments, saturating at TAPS; `full` is set when it reaches TAPS.
- **States:** FILL, IDLE, SEQ.
  - FILL → IDLE on the accepted write that makes the count reach TAPS. A burst request is raised on that same write.
  - IDLE → SEQ next cycle when a request is pending.
  - SEQ → IDLE after TAPS addresses, or SEQ → SEQ (back-to-back) if a request is pending.
- **Burst start:**
  - base = post-increment wr_ptr − TAPS, modulo 2^DEPTH_LOG2, latched at burst start.
  - `raddr` steps base, base+1, …, base+TAPS−1 with wrap.
- **Accepted write while in SEQ:**
  - The write proceeds; it never lands inside the current window because TAPS ≤ depth−2.
  - The pending flag is set.
  - A second accepted write in the same burst, with pending already set, is dropped as a request (the write itself still occurs) and sets `overrun`.
- **Simultaneous events:** an accepted write on the last SEQ cycle is treated as pending. The next burst starts on the following cycle, with base computed from the updated wr_ptr.
- **Reset values:** all outputs 0, state FILL, phase/pointers/count/pending 0. Reset mid-burst aborts immediately; the next burst requires a complete refill.

## Timing
- Accepted write in cycle T (while in FILL→full or IDLE) leads to `sequencing`=1 in cycles T+1..T+TAPS, with `raddr`=base at T+1.
- RAM read latency is 1 cycle: `rd_vld` in T+2..T+TAPS+1, `rd_first` at T+2, `rd_last` at T+TAPS+1.
- Back-to-back bursts: `sequencing` stays high with no gap cycle.
- `we`/`waddr` are combinational from the same cycle as `wrt_smpl`. No write latency.

## Configuration
- `CQ_OVERRUN_FLAG_EN`:
  - Defined: `overrun` is sticky as described and cleared only by reset.
  - Undefined: `overrun` is tied 0 and the extra request is silently dropped. Same port list either way.

## Structure
- Package `cq_pkg`:
  - DEPTH_LOG2/TAPS/DECIM default constants.
  - State enum typedef {FILL, IDLE, SEQ}.
  - Address typedef `cq_addr_t`.
- Sub-module `cq_decim`: phase counter producing `accept`.
- The RAM is instantiated by the parent, not here.

## Test plan
- **Fill:** 2042 `wrt_smpl` pulses (DECIM=2), then `we` on even pulses only, `waddr` 0..1020. After the 2042nd pulse, `full`=1 and a burst follows with `raddr` 0..1020, `rd_first`/`rd_last` at T+2/T+1022.
- **Wrap:** continue to the 1030th accepted write (`waddr`=5), then burst base 9, `raddr` 9..1023 then 0..5, 1021 addresses total.
- **Back-to-back:** one accepted write mid-burst, then the next burst starts the cycle after the last address, `sequencing` unbroken, new base = old base + 1.
- **Overrun:** two accepted writes in one burst. With `CQ_OVERRUN_FLAG_EN`: `overrun`=1 and stays set, exactly one follow-on burst. Without it: `overrun`=0, one follow-on burst.
- **Reset mid-burst:** `rst_n` low at address 500, then all outputs 0. After release, no burst until 1021 new accepted writes, first `raddr`=0.
- **DECIM=1, TAPS=4, DEPTH_LOG2=3:** every pulse writes. Check wrap every 8 writes, and that base never equals the live write address.
